awmc_panel_ctrl: RTL and testbench

//  Front-panel supervisor that drives the wash controller's start/pause inputs and watches its stage/done outputs.

---
 rtl/awmc_panel_ctrl.sv | 161 ++++++++++++++++
 tb/tb_awmc_panel_ctrl.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/awmc_panel_ctrl.sv
// Front-panel supervisor for the wash controller: debounced start/pause buttons,
// door lock, end-of-cycle buzzer and stuck-stage watchdog.
module awmc_panel_ctrl #(
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter int unsigned STAGE_TIMEOUT   = 32,
  parameter int unsigned BUZZ_CYCLES     = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_start_i,
  input  logic       btn_pause_i,
  input  logic       door_closed_i,
  input  logic [2:0] stage_i,
  input  logic       done_i,
  output logic       start_o,
  output logic       pause_o,
  output logic       door_lock_o,
  output logic       buzzer_o,
  output logic       fault_o,
  output logic [2:0] panel_state_o
);

  localparam int unsigned DB_W      = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int unsigned WD_W      = $clog2(STAGE_TIMEOUT + 1);
  localparam int unsigned BZ_W      = $clog2(BUZZ_CYCLES + 1);
  localparam int unsigned BTN_START = 0;
  localparam int unsigned BTN_PAUSE = 1;
  localparam logic [2:0]  STG_STOP  = 3'd4;
  localparam logic [2:0]  STG_IDLE  = 3'd7;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_RUN   = 3'd2,
    S_PAUSE = 3'd3,
    S_DONE  = 3'd4,
    S_FAULT = 3'd5
  } state_t;

  state_t state, state_d;

  logic [1:0]           btn_raw, btn_sync1, btn_sync2, btn_db, btn_db_q, btn_press;
  logic [1:0][DB_W-1:0] db_cnt;
  logic [2:0]           stage_q;
  logic [WD_W-1:0]      wd_cnt;
  logic [BZ_W-1:0]      buzz_cnt;
  logic                 cmpl, stage_moved, wd_expired, buzz_last;
  logic                 start_d, pause_d, lock_d, buzz_d, fault_d;

  assign btn_raw = {btn_pause_i, btn_start_i};

  // 2-FF synchroniser plus debounce; any sample equal to the current level restarts the count
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      btn_sync1 <= '0;
      btn_sync2 <= '0;
      btn_db    <= '0;
      btn_db_q  <= '0;
      db_cnt    <= '0;
    end else begin
      btn_sync1 <= btn_raw;
      btn_sync2 <= btn_sync1;
      btn_db_q  <= btn_db;
      for (int i = 0; i < 2; i++) begin
        if (btn_sync2[i] == btn_db[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == DB_W'(DEBOUNCE_CYCLES - 1)) begin
          btn_db[i] <= btn_sync2[i];
          db_cnt[i] <= '0;
        end else begin
          db_cnt[i] <= db_cnt[i] + DB_W'(1);
        end
      end
    end
  end

  assign btn_press = btn_db & ~btn_db_q;

  // done_i alone stays high after the first cycle, so completion is the STOP->IDLE step
  always_ff @(posedge clk or posedge reset) begin
    if (reset) stage_q <= '0;
    else       stage_q <= stage_i;
  end

  assign stage_moved = (stage_i != stage_q);
  assign cmpl        = (stage_q == STG_STOP) && (stage_i == STG_IDLE) && done_i;
  assign wd_expired  = (wd_cnt == WD_W'(STAGE_TIMEOUT - 1)) && !stage_moved;
  assign buzz_last   = (buzz_cnt == BZ_W'(BUZZ_CYCLES - 1));

  // Watchdog counts unchanged-stage cycles in RUN only; it holds its value while paused
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wd_cnt   <= '0;
      buzz_cnt <= '0;
    end else begin
      if (state_d == S_RUN && state != S_RUN)          wd_cnt <= '0;
      else if (state == S_RUN) begin
        if (stage_moved)                               wd_cnt <= '0;
        else if (wd_cnt != WD_W'(STAGE_TIMEOUT - 1))   wd_cnt <= wd_cnt + WD_W'(1);
      end
      if (state_d == S_DONE && state != S_DONE)        buzz_cnt <= '0;
      else if (state == S_DONE)                        buzz_cnt <= buzz_cnt + BZ_W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= S_IDLE;
      start_o     <= 1'b0;
      pause_o     <= 1'b0;
      door_lock_o <= 1'b0;
      buzzer_o    <= 1'b0;
      fault_o     <= 1'b0;
    end else begin
      state       <= state_d;
      start_o     <= start_d;
      pause_o     <= pause_d;
      door_lock_o <= lock_d;
      buzzer_o    <= buzz_d;
      fault_o     <= fault_d;
    end
  end

  assign panel_state_o = state;

  // Outputs decoded from the next state so they line up with the registered state
  always_comb begin
    state_d = state;
    start_d = 1'b0;
    pause_d = 1'b0;
    lock_d  = 1'b0;
    buzz_d  = 1'b0;
    fault_d = 1'b0;
    case (state)
      S_IDLE:  if (btn_press[BTN_START] && door_closed_i) state_d = S_START;
      S_START: state_d = S_RUN;
      S_RUN: begin
        if (!door_closed_i)              state_d = S_FAULT;
        else if (wd_expired)             state_d = S_FAULT;
        else if (btn_press[BTN_PAUSE])   state_d = S_PAUSE;
        else if (cmpl)                   state_d = S_DONE;
      end
      S_PAUSE: begin
        if (!door_closed_i)              state_d = S_FAULT;
        else if (|btn_press)             state_d = S_RUN;
      end
      S_DONE:  if (buzz_last) state_d = S_IDLE;
      S_FAULT: state_d = S_FAULT;
      default: state_d = S_IDLE;
    endcase
    case (state_d)
      S_START: begin start_d = 1'b1; lock_d = 1'b1; end
      S_RUN:   lock_d = 1'b1;
      S_PAUSE: begin pause_d = 1'b1; lock_d = 1'b1; end
      S_DONE:  buzz_d = 1'b1;
      S_FAULT: begin fault_d = 1'b1; pause_d = 1'b1; lock_d = 1'b1; end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_awmc_panel_ctrl.sv
// Bench for awmc_panel_ctrl: directed scenarios plus random button/door/stage
// traffic, every cycle compared against a behavioural panel model.
module tb_awmc_panel_ctrl;

  localparam int unsigned DB  = 4;
  localparam int unsigned TMO = 32;
  localparam int unsigned BZ  = 8;
  localparam int PH_IDLE = 0, PH_START = 1, PH_RUN = 2, PH_PAUSE = 3, PH_DONE = 4, PH_FAULT = 5;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       btn_start = 1'b0, btn_pause = 1'b0, door_closed = 1'b1, done = 1'b0;
  logic [2:0] stage = 3'd7;
  logic       start_o, pause_o, door_lock_o, buzzer_o, fault_o;
  logic [2:0] panel_state_o;
  logic [7:0] outs;

  int n_cmp = 0, n_err = 0;
  int n_start = 0, n_buzz = 0, n_buzz_lock = 0;

  awmc_panel_ctrl dut (
    .clk(clk), .reset(reset), .btn_start_i(btn_start), .btn_pause_i(btn_pause),
    .door_closed_i(door_closed), .stage_i(stage), .done_i(done),
    .start_o(start_o), .pause_o(pause_o), .door_lock_o(door_lock_o),
    .buzzer_o(buzzer_o), .fault_o(fault_o), .panel_state_o(panel_state_o)
  );

  always #5 clk = ~clk;

  assign outs = {panel_state_o, start_o, pause_o, door_lock_o, buzzer_o, fault_o};

  // Reference model: button history windows, panel phase and plain cycle counts
  logic [DB:0] hs = '0, hp = '0;
  bit          lvl_s = 0, lvl_p = 0, ev_s = 0, ev_p = 0;
  int          ph = PH_IDLE, unchanged = 0, done_cycles = 0;
  logic [2:0]  prev_stage = '0;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      hs = '0; hp = '0; lvl_s = 0; lvl_p = 0; ev_s = 0; ev_p = 0;
      ph = PH_IDLE; unchanged = 0; done_cycles = 0; prev_stage = '0;
    end else begin
      int nph;
      bit cmpl;
      cmpl = (prev_stage == 3'd4) && (stage == 3'd7) && done;
      nph = ph;
      case (ph)
        PH_IDLE:  if (ev_s && door_closed) nph = PH_START;
        PH_START: nph = PH_RUN;
        PH_RUN: begin
          unchanged = (stage == prev_stage) ? unchanged + 1 : 0;
          if (!door_closed)          nph = PH_FAULT;
          else if (unchanged >= TMO) nph = PH_FAULT;
          else if (ev_p)             nph = PH_PAUSE;
          else if (cmpl)             nph = PH_DONE;
        end
        PH_PAUSE: begin
          if (!door_closed)      nph = PH_FAULT;
          else if (ev_s || ev_p) nph = PH_RUN;
        end
        PH_DONE: begin
          done_cycles++;
          if (done_cycles == BZ) nph = PH_IDLE;
        end
        default: ;
      endcase
      if (nph == PH_RUN && ph != PH_RUN)   unchanged = 0;
      if (nph == PH_DONE && ph != PH_DONE) done_cycles = 0;
      // level flips once DB synchronised samples (raw delayed by two edges) all disagree with it
      ev_s = 0; ev_p = 0;
      if (hs[DB:1] == {DB{~lvl_s}}) begin lvl_s = ~lvl_s; ev_s = lvl_s; end
      if (hp[DB:1] == {DB{~lvl_p}}) begin lvl_p = ~lvl_p; ev_p = lvl_p; end
      hs = {hs[DB-1:0], btn_start};
      hp = {hp[DB-1:0], btn_pause};
      prev_stage = stage;
      ph = nph;
    end
  end

  function automatic logic [7:0] exp_vec();
    exp_vec = {3'(ph), ph == PH_START, (ph == PH_PAUSE) || (ph == PH_FAULT),
               (ph == PH_START) || (ph == PH_RUN) || (ph == PH_PAUSE) || (ph == PH_FAULT),
               ph == PH_DONE, ph == PH_FAULT};
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Advance n cycles; sample #1 after each edge against the model
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk); #1;
      if (!reset) chk("cycle", 32'(outs), 32'(exp_vec()));
      if (start_o) n_start++;
      if (buzzer_o) n_buzz++;
      if (buzzer_o && door_lock_o) n_buzz_lock++;
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    btn_start = 1'b0; btn_pause = 1'b0; door_closed = 1'b1; done = 1'b0; stage = 3'd7;
    tick(2);
    reset = 1'b0;
    n_start = 0; n_buzz = 0; n_buzz_lock = 0;
  endtask

  task automatic press(input bit pause_btn);
    if (pause_btn) btn_pause = 1'b1; else btn_start = 1'b1;
    tick(10);
    btn_pause = 1'b0; btn_start = 1'b0;
    tick(8);
  endtask

  task automatic run_random(input int cycles, input int hold_div);
    bit ts, tp;
    int bs, bp;
    ts = 0; tp = 0; bs = 0; bp = 0;
    for (int c = 0; c < cycles; c++) begin
      if ($urandom_range(0, 39) == 0) begin ts = ~ts; bs = int'($urandom_range(0, 5)); end
      if ($urandom_range(0, 59) == 0) begin tp = ~tp; bp = int'($urandom_range(0, 5)); end
      btn_start = (bs > 0) ? 1'($urandom_range(0, 1)) : ts;
      btn_pause = (bp > 0) ? 1'($urandom_range(0, 1)) : tp;
      if (bs > 0) bs--;
      if (bp > 0) bp--;
      door_closed = ($urandom_range(0, 1499) != 0);
      if ($urandom_range(0, hold_div - 1) == 0) begin
        if (stage == 3'd4 && $urandom_range(0, 2) != 0) begin
          stage = 3'd7; done = 1'b1;
        end else begin
          stage = 3'($urandom_range(0, 4)); done = ($urandom_range(0, 3) == 0);
        end
      end
      tick(1);
    end
  endtask

  initial begin
    int k;
    tick(3);
    chk("reset_outs", 32'(outs), 32'h0);
    reset = 1'b0;

    // Bouncing start: toggles every cycle, then holds
    do_reset();
    for (int i = 0; i < 10; i++) begin btn_start = ~btn_start; tick(1); end
    btn_start = 1'b1; tick(12);
    btn_start = 1'b0; tick(10);
    chk("bounce_pulses", n_start, 1);
    chk("bounce_state", panel_state_o, 3'd2);

    // Start with door open is ignored
    do_reset();
    door_closed = 1'b0;
    press(1'b0);
    chk("dooropen_start", n_start, 0);
    chk("dooropen_state", panel_state_o, 3'd0);

    // Full cycle through completion and buzzer
    do_reset();
    press(1'b0);
    chk("cycle_start", n_start, 1);
    chk("cycle_lock", door_lock_o, 1'b1);
    for (int s = 0; s < 5; s++) begin stage = 3'(s); tick(11); end
    chk("cycle_run", panel_state_o, 3'd2);
    stage = 3'd7; done = 1'b1;
    n_buzz = 0; n_buzz_lock = 0;
    tick(12);
    chk("buzz_len", n_buzz, BZ);
    chk("buzz_unlock", n_buzz_lock, 0);
    chk("cycle_idle", panel_state_o, 3'd0);

    // Long pause does not trip the watchdog; start resumes
    do_reset();
    stage = 3'd0;
    press(1'b0);
    stage = 3'd1; tick(5);
    press(1'b1);
    chk("pause_state", panel_state_o, 3'd3);
    chk("pause_o", pause_o, 1'b1);
    tick(60);
    chk("pause_nofault", fault_o, 1'b0);
    press(1'b0);
    chk("resume_state", panel_state_o, 3'd2);
    chk("resume_pause_o", pause_o, 1'b0);
    chk("resume_nofault", fault_o, 1'b0);

    // Stuck stage: fault after STAGE_TIMEOUT RUN cycles, sticky
    do_reset();
    stage = 3'd2;
    btn_start = 1'b1;
    for (k = 0; k < 40 && panel_state_o != 3'd2; k++) tick(1);
    chk("wd_run", panel_state_o, 3'd2);
    btn_start = 1'b0;
    for (k = 0; k < 60 && !fault_o; k++) tick(1);
    chk("wd_latency", k, TMO);
    press(1'b0);
    press(1'b1);
    chk("wd_sticky", {fault_o, pause_o, panel_state_o}, {1'b1, 1'b1, 3'd5});

    // Asynchronous reset mid-run, then a clean restart
    do_reset();
    stage = 3'd2;
    press(1'b0);
    tick(3);
    #2 reset = 1'b1;
    #1 chk("async_reset", 32'(outs), 32'h0);
    tick(2);
    reset = 1'b0;
    n_start = 0;
    press(1'b0);
    chk("restart_state", panel_state_o, 3'd2);
    chk("restart_start", n_start, 1);

    // Random traffic, alternating fast- and slow-changing stage
    for (int seg = 0; seg < 6; seg++) begin
      do_reset();
      run_random(1200, (seg % 2 == 0) ? 12 : 48);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
